ascon_perm_ctrl: RTL

Sequencer that drives the combinational `asconp` round core and turns it into an iterative, handshaked Ascon-p permutation engine. Accepts a 320-bit state plus a round count on a valid/ready input port, applies UROL rounds per clock, and returns the permuted state on a valid/ready output port. Sits between the mode controller (Ascon-128/128a/Hash) and the round core; it owns the state register and the round counter that `asconp` consumes.

---
 rtl/ascon_pkg.sv | 21 ++
 rtl/asconp.sv | 74 +++++++
 rtl/ascon_perm_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - shared constants, FSM encoding and round-count legality for the Ascon-p engine
package ascon_pkg;

  localparam int UROL = 1;

  localparam logic [3:0] ROUNDS_PA  = 4'd12;
  localparam logic [3:0] ROUNDS_PB6 = 4'd6;
  localparam logic [3:0] ROUNDS_PB8 = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_t;

  // Zero is legal here; the caller decides whether a legal request needs a RUN phase.
  function automatic logic is_legal_rounds(input logic [3:0] rounds, input int urol);
    return (rounds <= ROUNDS_PA) && ((int'(rounds) % urol) == 0);
  endfunction

endpackage

// File: rtl/asconp.sv
// rtl/asconp.sv - combinational Ascon-p round core, UROL unrolled rounds driven by the remaining-round count
module asconp
  import ascon_pkg::*;
(
  input  logic [3:0]  round_cnt,
  input  logic [63:0] x0_i,
  input  logic [63:0] x1_i,
  input  logic [63:0] x2_i,
  input  logic [63:0] x3_i,
  input  logic [63:0] x4_i,
  output logic [63:0] x0_o,
  output logic [63:0] x1_o,
  output logic [63:0] x2_o,
  output logic [63:0] x3_o,
  output logic [63:0] x4_o
);

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // r is the remaining count before this round; r=12 is the first round of a full p^12.
  function automatic logic [4:0][63:0] ascon_round(input logic [4:0][63:0] s, input logic [3:0] r);
    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] t0, t1, t2, t3, t4;
    logic [3:0]  c_hi, c_lo;
    logic [4:0][63:0] res;
    c_hi = r + 4'd3;
    c_lo = 4'd12 - r;
    a0 = s[0];
    a1 = s[1];
    a2 = s[2] ^ {56'd0, c_hi, c_lo};
    a3 = s[3];
    a4 = s[4];
    a0 = a0 ^ a4;
    a4 = a4 ^ a3;
    a2 = a2 ^ a1;
    t0 = ~a0 & a1;
    t1 = ~a1 & a2;
    t2 = ~a2 & a3;
    t3 = ~a3 & a4;
    t4 = ~a4 & a0;
    a0 = a0 ^ t1;
    a1 = a1 ^ t2;
    a2 = a2 ^ t3;
    a3 = a3 ^ t4;
    a4 = a4 ^ t0;
    a1 = a1 ^ a0;
    a0 = a0 ^ a4;
    a3 = a3 ^ a2;
    a2 = ~a2;
    res[0] = a0 ^ rotr(a0, 19) ^ rotr(a0, 28);
    res[1] = a1 ^ rotr(a1, 61) ^ rotr(a1, 39);
    res[2] = a2 ^ rotr(a2, 1)  ^ rotr(a2, 6);
    res[3] = a3 ^ rotr(a3, 10) ^ rotr(a3, 17);
    res[4] = a4 ^ rotr(a4, 7)  ^ rotr(a4, 41);
    return res;
  endfunction

  logic [4:0][63:0] stage [UROL+1];

  assign stage[0] = {x4_i, x3_i, x2_i, x1_i, x0_i};

  for (genvar k = 0; k < UROL; k++) begin : g_round
    assign stage[k+1] = ascon_round(stage[k], round_cnt - 4'(k));
  end

  assign x0_o = stage[UROL][0];
  assign x1_o = stage[UROL][1];
  assign x2_o = stage[UROL][2];
  assign x3_o = stage[UROL][3];
  assign x4_o = stage[UROL][4];

endmodule

// File: rtl/ascon_perm_ctrl.sv
// rtl/ascon_perm_ctrl.sv - handshaked iterative Ascon-p permutation engine around the asconp round core
module ascon_perm_ctrl
  import ascon_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  rounds_i,
  input  logic [63:0] x0_i,
  input  logic [63:0] x1_i,
  input  logic [63:0] x2_i,
  input  logic [63:0] x3_i,
  input  logic [63:0] x4_i,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] x0_o,
  output logic [63:0] x1_o,
  output logic [63:0] x2_o,
  output logic [63:0] x3_o,
  output logic [63:0] x4_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam logic [3:0] UROL_4 = 4'(UROL);

  fsm_t             fsm, fsm_nxt;
  logic [4:0][63:0] st;
  logic [3:0]       rcnt;
  logic [63:0]      p0, p1, p2, p3, p4;
  logic             accept, req_legal, req_run;

  assign accept    = in_valid && in_ready;
  assign req_legal = is_legal_rounds(rounds_i, UROL);
  assign req_run   = req_legal && (rounds_i != 4'd0);

  asconp u_core (
    .round_cnt (rcnt),
    .x0_i      (st[0]),
    .x1_i      (st[1]),
    .x2_i      (st[2]),
    .x3_i      (st[3]),
    .x4_i      (st[4]),
    .x0_o      (p0),
    .x1_o      (p1),
    .x2_o      (p2),
    .x3_o      (p3),
    .x4_o      (p4)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm <= ST_IDLE;
    end else begin
      fsm <= fsm_nxt;
    end
  end

  always_comb begin
    fsm_nxt = fsm;
    unique case (fsm)
      ST_IDLE: begin
        if (accept) fsm_nxt = req_run ? ST_RUN : ST_DONE;
      end
      ST_RUN: begin
        if (rcnt == UROL_4) fsm_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (accept)         fsm_nxt = req_run ? ST_RUN : ST_DONE;
        else if (out_ready) fsm_nxt = ST_IDLE;
      end
      default: fsm_nxt = ST_IDLE;
    endcase
  end

  // in_ready depends only on the registered FSM and out_ready, never on in_valid.
  always_comb begin
    in_ready  = (fsm == ST_IDLE) || ((fsm == ST_DONE) && out_ready);
    out_valid = (fsm == ST_DONE);
    busy_o    = (fsm == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= '0;
      rcnt  <= 4'd0;
      err_o <= 1'b0;
    end else begin
      err_o <= 1'b0;
      if (accept) begin
        st    <= {x4_i, x3_i, x2_i, x1_i, x0_i};
        rcnt  <= rounds_i;
        err_o <= !req_legal;
      end else if (fsm == ST_RUN) begin
        st    <= {p4, p3, p2, p1, p0};
        rcnt  <= rcnt - UROL_4;
      end
    end
  end

  assign x0_o = st[0];
  assign x1_o = st[1];
  assign x2_o = st[2];
  assign x3_o = st[3];
  assign x4_o = st[4];

endmodule
